// File: rtl/hdmi_framer.sv
// hdmi_framer: buffers an RGB valid/ready stream in a small FIFO and regenerates
// HDMI raster timing (vs/de/data). Define HDMI_FRAMER_PATTERN_EN for the built-in test pattern.
module hdmi_framer #(
    parameter int H_ACTIVE    = 64,
    parameter int V_ACTIVE    = 64,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8
) (
    input  logic        hdmi_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pattern_en,
    input  logic        in_valid,
    input  logic [23:0] in_data,
    output logic        in_ready,
    output logic        hdmi_vs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic        underflow,
    output logic [7:0]  frame_cnt
);
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state, state_nxt;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          run, h_last, v_last, vs_region, de_region, pat;
    logic          vs_nxt, de_nxt;
    logic [31:0]   data_nxt;

`ifdef HDMI_FRAMER_PATTERN_EN
    logic [7:0] px, py, pxy;
    assign pat = pattern_en;
    assign px  = 8'(h_cnt) - 8'(H_BLANK);
    assign py  = 8'(v_cnt) - 8'(V_BLANK);
    assign pxy = px ^ py;
`else
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;
    assign pat = 1'b0;
`endif

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = ~full & rst_n;
    assign push     = in_valid & in_ready;

    assign run       = (state == RUN);
    assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
    assign vs_region = (v_cnt >= VW'(V_BLANK));
    assign de_region = vs_region & (h_cnt >= HW'(H_BLANK));
    assign vs_nxt    = run & vs_region;
    assign de_nxt    = run & de_region;
    // Timing never stalls: an empty FIFO in a de slot just yields a zero pixel.
    assign pop       = de_nxt & ~empty & ~pat;

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME: begin
                if (!enable)                                         state_nxt = IDLE;
                else if (pat || count >= (AW+1)'(START_LEVEL))        state_nxt = RUN;
            end
            // Only leave at the last pixel of the frame so a frame is never truncated.
            RUN:     if (!enable && h_last && v_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge hdmi_clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        data_nxt = '0;
        if (pop) data_nxt = {8'h00, mem[rd_ptr]};
`ifdef HDMI_FRAMER_PATTERN_EN
        if (de_nxt && pat) data_nxt = {8'h00, px[5:0], 2'b00, py[5:0], 2'b00, pxy[5:0], 2'b00};
`endif
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdmi_vs   <= 1'b0;
            hdmi_de   <= 1'b0;
            hdmi_data <= '0;
            underflow <= 1'b0;
            frame_cnt <= '0;
        end else begin
            hdmi_vs   <= vs_nxt;
            hdmi_de   <= de_nxt;
            hdmi_data <= data_nxt;
            if (hdmi_vs && !vs_nxt) frame_cnt <= frame_cnt + 8'd1;
            // The vs rise is at h_cnt=0, so it can never coincide with an empty de slot.
            if (vs_nxt && !hdmi_vs)           underflow <= 1'b0;
            else if (de_nxt && empty && !pat) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hdmi_framer.sv
// Scoreboard bench for hdmi_framer: accepted pixels are queued with their push cycle,
// a negedge monitor pops them at every de slot and checks frame timing.
module tb_hdmi_framer;
    localparam int H_ACTIVE  = 64;
    localparam int V_ACTIVE  = 64;
    localparam int H_BLANK   = 16;
    localparam int V_BLANK   = 4;
    localparam int H_TOTAL   = H_BLANK + H_ACTIVE;
    localparam int FRAME_DE  = H_ACTIVE * V_ACTIVE;
    localparam int VS_LEN    = V_ACTIVE * H_TOTAL;
    localparam int PRIME_LAT = 2 + V_BLANK * H_TOTAL;

    logic        hdmi_clk = 1'b0;
    logic        rst_n = 1'b0, enable = 1'b0, pattern_en = 1'b0, in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, hdmi_vs, hdmi_de, underflow;
    logic [31:0] hdmi_data;
    logic [7:0]  frame_cnt;

    hdmi_framer dut (
        .hdmi_clk(hdmi_clk), .rst_n(rst_n), .enable(enable), .pattern_en(pattern_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de), .hdmi_data(hdmi_data),
        .underflow(underflow), .frame_cnt(frame_cnt)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    typedef struct {
        logic [23:0] px;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0, checks = 0, fails = 0, n_acc = 0, last_stamp = 0;
    bit   src_on = 0, src_rand = 0;
    int   src_rate = 8, src_lim = -1;

    always @(posedge hdmi_clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_vs(input logic lvl, input int lim, input string nm);
        int n = 0;
        do begin
            @(negedge hdmi_clk);
            n++;
        end while (hdmi_vs !== lvl && n < lim);
        if (hdmi_vs !== lvl) begin
            checks++;
            fails++;
            $display("FAIL %s: hdmi_vs never reached %0b within %0d cycles", nm, lvl, lim);
        end
    endtask

    task automatic wait_acc(input int target, input int lim, input string nm);
        int n = 0;
        while (n_acc < target && n < lim) begin
            @(posedge hdmi_clk);
            #2;
            n++;
        end
        if (n_acc < target) begin
            checks++;
            fails++;
            $display("FAIL %s: accepted %0d want %0d", nm, n_acc, target);
        end
    endtask

    task automatic do_reset();
        @(posedge hdmi_clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge hdmi_clk);
        @(posedge hdmi_clk);
        #3 rst_n = 1'b1;
    endtask

    // Source: offers a pixel each cycle (with probability src_rate/8) and records
    // every accepted pixel with the cycle number it lands in the FIFO.
    always begin
        @(posedge hdmi_clk);
        #1;
        if (src_on && (src_lim < 0 || n_acc < src_lim) && $urandom_range(7, 0) < src_rate) begin
            in_valid = 1'b1;
            in_data  = src_rand ? 24'($urandom) : 24'(n_acc + 1);
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        @(negedge hdmi_clk);
        if (!rst_n) exp_q.delete();
        else if (in_valid && in_ready) begin
            exp_q.push_back('{px: in_data, stamp: cyc + 1});
            last_stamp = cyc + 1;
            n_acc++;
        end
    end

    // Monitor: a pixel pushed in cycle N may be shown from cycle N+2 onward.
    logic        vs_q = 1'b0;
    bit          in_fr = 0, exp_uf = 0, pat_mode;
    logic [7:0]  exp_fc = '0;
    int          rise_c = 0, first_de = -1, last_de = 0, de_n = 0, pos, px, py;
    logic [31:0] expd;
    exp_t        e;

    always @(negedge hdmi_clk) begin
        if (!rst_n) begin
            vs_q = 1'b0; in_fr = 0; exp_uf = 0; exp_fc = '0;
            chk("rst_flags", {28'd0, hdmi_vs, hdmi_de, underflow, in_ready}, 32'd0);
            chk("rst_data", hdmi_data, 32'd0);
            chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        end else begin
            if (hdmi_vs && !vs_q) begin
                rise_c = cyc; in_fr = 1; de_n = 0; first_de = -1; exp_uf = 0;
            end
            pat_mode = 1'b0;
`ifdef HDMI_FRAMER_PATTERN_EN
            pat_mode = pattern_en;
`endif
            if (hdmi_de) begin
                chk("de_inside_vs", 32'(hdmi_vs), 32'd1);
                if (first_de < 0) first_de = cyc;
                last_de = cyc;
                de_n++;
                expd = '0;
                if (pat_mode) begin
                    pos  = cyc - rise_c;
                    px   = pos % H_TOTAL - H_BLANK;
                    py   = pos / H_TOTAL;
                    expd = {8'h00, 8'((px & 63) << 2), 8'((py & 63) << 2), 8'(((px ^ py) & 63) << 2)};
`ifdef HDMI_FRAMER_PATTERN_EN
                    if (px == 3 && py == 5) chk("pat_3_5", hdmi_data, 32'h000C1418);
`endif
                end else if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                    e    = exp_q.pop_front();
                    expd = {8'h00, e.px};
                end else begin
                    exp_uf = 1;
                end
                chk("de_data", hdmi_data, expd);
            end else begin
                chk("blank_data", hdmi_data, 32'd0);
            end
            if (!hdmi_vs && vs_q) begin
                exp_fc = exp_fc + 8'd1;
                chk("fcnt_step", 32'(frame_cnt), 32'(exp_fc));
                if (in_fr) begin
                    chk("de_per_frame", de_n, FRAME_DE);
                    chk("vs_length", cyc - rise_c, VS_LEN);
                    chk("first_de_offset", first_de - rise_c, H_BLANK);
                    chk("last_de_before_fall", cyc - last_de, 1);
                end
                in_fr = 0;
            end
            chk("underflow", 32'(underflow), 32'(exp_uf));
            vs_q = hdmi_vs;
        end
    end

    initial begin
        int base, st, hi;
        repeat (3) @(negedge hdmi_clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge hdmi_clk);
        #3 rst_n = 1'b1;
        @(negedge hdmi_clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        chk("fcnt_after_rst", 32'(frame_cnt), 32'd0);

        // Backpressure while idle: 16 fit, the 17th is refused.
        src_on = 1;
        wait_acc(16, 100, "bp_fill");
        repeat (5) @(negedge hdmi_clk);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_accepted", n_acc, 16);

        // Continuous ramp, two full frames.
        enable = 1'b1;
        wait_vs(1'b1, 1000, "c_rise1");
        wait_vs(1'b0, 6000, "c_fall1");
        wait_vs(1'b1, 1000, "c_rise2");
        wait_vs(1'b0, 6000, "c_fall2");

        // Drop enable at line 10: frame completes, then everything idles.
        wait_vs(1'b1, 1000, "d_rise");
        repeat (10 * H_TOTAL) @(negedge hdmi_clk);
        enable = 1'b0;
        wait_vs(1'b0, 6000, "d_fall");
        repeat (1000) begin
            @(negedge hdmi_clk);
            chk("d_idle_vsde", {30'd0, hdmi_vs, hdmi_de}, 32'd0);
            chk("d_fcnt_stable", 32'(frame_cnt), 32'd3);
        end

        // Starvation after 100 pixels, then the source resumes.
        src_on = 0;
        do_reset();
        base = n_acc; src_lim = base + 100; src_on = 1; enable = 1'b1;
        wait_vs(1'b1, 2000, "e_rise1");
        wait_vs(1'b0, 6000, "e_fall1");
        chk("uf_starved", 32'(underflow), 32'd1);
        src_lim = -1;
        wait_vs(1'b1, 2000, "e_rise2");
        chk("uf_cleared", 32'(underflow), 32'd0);
        wait_vs(1'b0, 6000, "e_fall2");

        // Asynchronous reset mid-line, then PRIME must be re-earned.
        wait_vs(1'b1, 2000, "f_rise1");
        repeat (10 * H_TOTAL + 40) @(posedge hdmi_clk);
        #3 rst_n = 1'b0;
        src_on = 0;
        #1;
        chk("mid_rst_vsde", {30'd0, hdmi_vs, hdmi_de}, 32'd0);
        chk("mid_rst_data", hdmi_data, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge hdmi_clk);
        @(posedge hdmi_clk);
        #3 rst_n = 1'b1;
        @(negedge hdmi_clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        hi = 0;
        repeat (6000) begin
            @(negedge hdmi_clk);
            if (hdmi_vs) hi++;
        end
        chk("prime_hold_no_vs", hi, 0);
        base = n_acc; src_rate = 8; src_rand = 0; src_lim = base + 8; src_on = 1;
        wait_acc(base + 8, 200, "f_prime8");
        st = last_stamp;
        src_lim = -1; src_rand = 1; src_rate = 7;
        wait_vs(1'b1, 2000, "f_rise2");
        chk("prime_latency", cyc - st, PRIME_LAT);
        wait_vs(1'b0, 6000, "f_fall2");

`ifdef HDMI_FRAMER_PATTERN_EN
        src_on = 0; enable = 1'b0;
        do_reset();
        pattern_en = 1'b1; enable = 1'b1;
        wait_vs(1'b1, 2000, "p_rise");
        wait_vs(1'b0, 6000, "p_fall");
        pattern_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
